// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: three independent requester ports (L, M, R) sharing a
// three-port RAM cell matrix. Each port runs an IDLE/ISSUE/ACK sequencer;
// same-address accesses involving a write are serialised round-robin.
// Optional feature macro: ARB_CONFLICT_CNT_EN adds a saturating 16-bit
// count of deferred grants on output conflict_cnt.
module ram_port_arbiter #(
  parameter int N             = 16,
  parameter int no_addr_lines = 4,
  parameter int wordsize      = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  // left requester / matrix side
  input  logic                     L_req,
  input  logic                     L_we,
  input  logic [no_addr_lines-1:0] L_addr,
  input  logic [wordsize-1:0]      L_wdata,
  output logic                     L_ack,
  output logic [wordsize-1:0]      L_rdata,
  output logic [no_addr_lines-1:0] L_address,
  output logic                     L_write,
  output logic [wordsize-1:0]      L_Data_Bit_Line,
  input  logic [wordsize-1:0]      L_Data_Bit_Line_read,
  // middle requester / matrix side
  input  logic                     M_req,
  input  logic                     M_we,
  input  logic [no_addr_lines-1:0] M_addr,
  input  logic [wordsize-1:0]      M_wdata,
  output logic                     M_ack,
  output logic [wordsize-1:0]      M_rdata,
  output logic [no_addr_lines-1:0] M_address,
  output logic                     M_write,
  output logic [wordsize-1:0]      M_Data_Bit_Line,
  input  logic [wordsize-1:0]      M_Data_Bit_Line_read,
  // right requester / matrix side
  input  logic                     R_req,
  input  logic                     R_we,
  input  logic [no_addr_lines-1:0] R_addr,
  input  logic [wordsize-1:0]      R_wdata,
  output logic                     R_ack,
  output logic [wordsize-1:0]      R_rdata,
  output logic [no_addr_lines-1:0] R_address,
  output logic                     R_write,
  output logic [wordsize-1:0]      R_Data_Bit_Line,
  input  logic [wordsize-1:0]      R_Data_Bit_Line_read
`ifdef ARB_CONFLICT_CNT_EN
  ,
  output logic [15:0]              conflict_cnt
`endif
);

  // The matrix depth must match the address width.
  if (N != (1 << no_addr_lines)) begin : g_bad_depth
    $error("ram_port_arbiter: N must equal 2**no_addr_lines");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, ACK} state_t;

  // Port index 0 = L, 1 = M, 2 = R.
  localparam logic [1:0] PORT_L = 2'd0;

  logic [2:0]               req;
  logic [2:0]               we;
  logic [no_addr_lines-1:0] addr    [3];
  logic [wordsize-1:0]      wdata   [3];
  logic [wordsize-1:0]      rdline  [3];

  state_t                   st      [3];
  logic [no_addr_lines-1:0] address_q [3];
  logic [wordsize-1:0]      dbl_q   [3];
  logic [2:0]               write_q;
  logic [2:0]               ack_q;
  logic [wordsize-1:0]      rdata_q [3];

  logic [1:0] rr;
  logic [2:0] elig;
  logic [2:0] cf;
  logic [2:0] grant;
  logic [1:0] win;
  logic [1:0] idx;
  logic       found;

  // Step a port index forward by k positions in L->M->R->L order.
  function automatic logic [1:0] rr_add(input logic [1:0] base, input logic [1:0] k);
    logic [2:0] s;
    s = {1'b0, base} + {1'b0, k};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  assign req       = {R_req, M_req, L_req};
  assign we        = {R_we, M_we, L_we};
  assign addr[0]   = L_addr;
  assign addr[1]   = M_addr;
  assign addr[2]   = R_addr;
  assign wdata[0]  = L_wdata;
  assign wdata[1]  = M_wdata;
  assign wdata[2]  = R_wdata;
  assign rdline[0] = L_Data_Bit_Line_read;
  assign rdline[1] = M_Data_Bit_Line_read;
  assign rdline[2] = R_Data_Bit_Line_read;

  assign L_ack           = ack_q[0];
  assign M_ack           = ack_q[1];
  assign R_ack           = ack_q[2];
  assign L_rdata         = rdata_q[0];
  assign M_rdata         = rdata_q[1];
  assign R_rdata         = rdata_q[2];
  assign L_address       = address_q[0];
  assign M_address       = address_q[1];
  assign R_address       = address_q[2];
  assign L_write         = write_q[0];
  assign M_write         = write_q[1];
  assign R_write         = write_q[2];
  assign L_Data_Bit_Line = dbl_q[0];
  assign M_Data_Bit_Line = dbl_q[1];
  assign R_Data_Bit_Line = dbl_q[2];

  // Arbitration: grant every conflict-free eligible port, plus one
  // round-robin winner out of the ports that collide. Colliding ports
  // always share one address, so there is at most one conflicting set.
  always_comb begin
    elig  = '0;
    cf    = '0;
    grant = '0;
    win   = PORT_L;
    idx   = PORT_L;
    found = 1'b0;
    for (int i = 0; i < 3; i++) begin
      elig[i] = req[i] && (st[i] == IDLE);
    end
    for (int i = 0; i < 3; i++) begin
      for (int j = i + 1; j < 3; j++) begin
        if (elig[i] && elig[j] && (addr[i] == addr[j]) && (we[i] || we[j])) begin
          cf[i] = 1'b1;
          cf[j] = 1'b1;
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      idx = rr_add(rr, 2'(k));
      if (!found && cf[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    grant = elig & ~cf;
    if (found) grant[win] = 1'b1;
  end

  // Per-port sequencers and the round-robin pointer; reset aborts any
  // in-flight access and drops the write strobes immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr      <= PORT_L;
      write_q <= '0;
      ack_q   <= '0;
      for (int i = 0; i < 3; i++) begin
        st[i]        <= IDLE;
        address_q[i] <= '0;
        dbl_q[i]     <= '0;
        rdata_q[i]   <= '0;
      end
    end else begin
      if (found) rr <= rr_add(win, 2'd1);
      for (int i = 0; i < 3; i++) begin
        case (st[i])
          IDLE: begin
            ack_q[i] <= 1'b0;
            if (grant[i]) begin
              address_q[i] <= addr[i];
              dbl_q[i]     <= wdata[i];
              write_q[i]   <= we[i];
              st[i]        <= ISSUE;
            end
          end
          ISSUE: begin
            write_q[i] <= 1'b0;
            ack_q[i]   <= 1'b1;
            if (!write_q[i]) rdata_q[i] <= rdline[i];
            st[i]      <= ACK;
          end
          ACK: begin
            ack_q[i] <= 1'b0;
            st[i]    <= IDLE;
          end
          default: begin
            write_q[i] <= 1'b0;
            ack_q[i]   <= 1'b0;
            st[i]      <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef ARB_CONFLICT_CNT_EN
  logic [1:0] deferred;

  // Add without wrapping: stick at all-ones once the count overflows.
  function automatic logic [15:0] sat_add(input logic [15:0] c, input logic [1:0] d);
    logic [16:0] s;
    s = {1'b0, c} + {15'd0, d};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Ports deferred this cycle = size of the conflicting set minus the winner.
  always_comb begin
    deferred = 2'd0;
    if (found) deferred = 2'(cf[0]) + 2'(cf[1]) + 2'(cf[2]) - 2'd1;
  end

  // Saturating tally of deferred grants.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) conflict_cnt <= '0;
    else if (found) conflict_cnt <= sat_add(conflict_cnt, deferred);
  end
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: directed transactions push their
// expected ack cycle and read data; a monitor pops on every ack.
module tb_ram_port_arbiter;

  logic       clk;
  logic       rst_n;
  logic       L_req, M_req, R_req;
  logic       L_we, M_we, R_we;
  logic [3:0] L_addr, M_addr, R_addr;
  logic [7:0] L_wdata, M_wdata, R_wdata;
  logic       L_ack, M_ack, R_ack;
  logic [7:0] L_rdata, M_rdata, R_rdata;
  logic [3:0] L_address, M_address, R_address;
  logic       L_write, M_write, R_write;
  logic [7:0] L_dbl, M_dbl, R_dbl;
  logic [7:0] L_rd, M_rd, R_rd;
`ifdef ARB_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt;
`endif

  ram_port_arbiter #(.N(16), .no_addr_lines(4), .wordsize(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .L_req(L_req), .L_we(L_we), .L_addr(L_addr), .L_wdata(L_wdata),
    .L_ack(L_ack), .L_rdata(L_rdata), .L_address(L_address), .L_write(L_write),
    .L_Data_Bit_Line(L_dbl), .L_Data_Bit_Line_read(L_rd),
    .M_req(M_req), .M_we(M_we), .M_addr(M_addr), .M_wdata(M_wdata),
    .M_ack(M_ack), .M_rdata(M_rdata), .M_address(M_address), .M_write(M_write),
    .M_Data_Bit_Line(M_dbl), .M_Data_Bit_Line_read(M_rd),
    .R_req(R_req), .R_we(R_we), .R_addr(R_addr), .R_wdata(R_wdata),
    .R_ack(R_ack), .R_rdata(R_rdata), .R_address(R_address), .R_write(R_write),
    .R_Data_Bit_Line(R_dbl), .R_Data_Bit_Line_read(R_rd)
`ifdef ARB_CONFLICT_CNT_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  // Behavioural three-port cell matrix: word i starts as 8'h30+i.
  logic [7:0] mem [16];
  initial for (int i = 0; i < 16; i++) mem[i] <= 8'h30 + 8'(i);
  always @(posedge clk) begin
    if (L_write) mem[L_address] <= L_dbl;
    if (M_write) mem[M_address] <= M_dbl;
    if (R_write) mem[R_address] <= R_dbl;
  end
  assign L_rd = mem[L_address];
  assign M_rd = mem[M_address];
  assign R_rd = mem[R_address];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int         cyc;
    bit         rd;
    logic [7:0] data;
  } exp_t;
  exp_t q_l[$];
  exp_t q_m[$];
  exp_t q_r[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic expect_ack(input int p, input int c, input bit rd, input logic [7:0] d);
    exp_t e;
    e.cyc = c; e.rd = rd; e.data = d;
    case (p)
      0: q_l.push_back(e);
      1: q_m.push_back(e);
      default: q_r.push_back(e);
    endcase
  endtask

  task automatic mon(input int p, input logic ack, input logic [7:0] rdata);
    exp_t e;
    bit   empty;
    if (ack !== 1'b1) return;
    empty = 1'b0;
    case (p)
      0: if (q_l.size() == 0) empty = 1'b1; else e = q_l.pop_front();
      1: if (q_m.size() == 0) empty = 1'b1; else e = q_m.pop_front();
      default: if (q_r.size() == 0) empty = 1'b1; else e = q_r.pop_front();
    endcase
    if (empty) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_ack port=%0d actual=ack@%0d required=no_ack", p, cyc);
    end else begin
      chk($sformatf("ack_cycle_p%0d", p), cyc, e.cyc);
      if (e.rd) chk($sformatf("rdata_p%0d", p), {24'd0, rdata}, {24'd0, e.data});
    end
  endtask

  // Monitor: compare every ack against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, L_ack, L_rdata);
      mon(1, M_ack, M_rdata);
      mon(2, R_ack, R_rdata);
    end
  end

  task automatic drive(input int p, input logic we, input logic [3:0] a, input logic [7:0] d);
    case (p)
      0: begin L_we = we; L_addr = a; L_wdata = d; L_req = 1'b1; end
      1: begin M_we = we; M_addr = a; M_wdata = d; M_req = 1'b1; end
      default: begin R_we = we; R_addr = a; R_wdata = d; R_req = 1'b1; end
    endcase
  endtask

  // Drop each request as its ack shows up; bounded wait.
  task automatic wait_done(input bit [2:0] mask);
    bit [2:0] pend;
    pend = mask;
    for (int t = 0; t < 12 && pend != 3'b000; t++) begin
      @(negedge clk);
      if (pend[0] && L_ack) begin pend[0] = 1'b0; L_req = 1'b0; end
      if (pend[1] && M_ack) begin pend[1] = 1'b0; M_req = 1'b0; end
      if (pend[2] && R_ack) begin pend[2] = 1'b0; R_req = 1'b0; end
    end
    chk("ack_timeout_pending", {29'd0, pend}, 32'd0);
    @(negedge clk);
  endtask

  int c;

  initial begin
    rst_n = 1'b0;
    L_req = 0; M_req = 0; R_req = 0;
    L_we = 0; M_we = 0; R_we = 0;
    L_addr = 0; M_addr = 0; R_addr = 0;
    L_wdata = 0; M_wdata = 0; R_wdata = 0;
    repeat (3) @(negedge clk);
    chk("rst_acks", {29'd0, L_ack, M_ack, R_ack}, 32'd0);
    chk("rst_writes", {29'd0, L_write, M_write, R_write}, 32'd0);
    chk("rst_address", {20'd0, L_address, M_address, R_address}, 32'd0);
    chk("rst_dbl", {8'd0, L_dbl, M_dbl, R_dbl}, 32'd0);
    chk("rst_rdata", {8'd0, L_rdata, M_rdata, R_rdata}, 32'd0);
    chk("rst_rr", {30'd0, dut.rr}, 32'd0);
`ifdef ARB_CONFLICT_CNT_EN
    chk("rst_cnt", {16'd0, conflict_cnt}, 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Three reads of distinct addresses: all acked together.
    @(negedge clk); c = cyc;
    drive(0, 0, 4'd1, 8'h00); drive(1, 0, 4'd2, 8'h00); drive(2, 0, 4'd3, 8'h00);
    expect_ack(0, c + 2, 1, 8'h31); expect_ack(1, c + 2, 1, 8'h32); expect_ack(2, c + 2, 1, 8'h33);
    wait_done(3'b111);

    // L and R write address 5, rr=L: L first, R one cycle later.
    c = cyc;
    drive(0, 1, 4'd5, 8'hAA); drive(2, 1, 4'd5, 8'h55);
    expect_ack(0, c + 2, 0, 8'h00); expect_ack(2, c + 3, 0, 8'h00);
    wait_done(3'b101);
    chk("rr_after_write_pair", {30'd0, dut.rr}, 32'd1);
`ifdef ARB_CONFLICT_CNT_EN
    chk("cnt_after_write_pair", {16'd0, conflict_cnt}, 32'd1);
`endif
    c = cyc;
    drive(0, 0, 4'd5, 8'h00);
    expect_ack(0, c + 2, 1, 8'h55);
    wait_done(3'b001);

    // Two reads of the same address do not conflict.
    c = cyc;
    drive(0, 0, 4'd7, 8'h00); drive(1, 0, 4'd7, 8'h00);
    expect_ack(0, c + 2, 1, 8'h37); expect_ack(1, c + 2, 1, 8'h37);
    wait_done(3'b011);
    chk("rr_after_shared_read", {30'd0, dut.rr}, 32'd1);
`ifdef ARB_CONFLICT_CNT_EN
    chk("cnt_after_shared_read", {16'd0, conflict_cnt}, 32'd1);
`endif

    // Three writes to address 0 with rr=M: order M, R, L.
    c = cyc;
    drive(0, 1, 4'd0, 8'h11); drive(1, 1, 4'd0, 8'h22); drive(2, 1, 4'd0, 8'h33);
    expect_ack(1, c + 2, 0, 8'h00); expect_ack(2, c + 3, 0, 8'h00); expect_ack(0, c + 4, 0, 8'h00);
    wait_done(3'b111);
    chk("rr_after_triple_write", {30'd0, dut.rr}, 32'd0);
`ifdef ARB_CONFLICT_CNT_EN
    chk("cnt_after_triple_write", {16'd0, conflict_cnt}, 32'd4);
`endif
    c = cyc;
    drive(1, 0, 4'd0, 8'h00);
    expect_ack(1, c + 2, 1, 8'h11);
    wait_done(3'b010);

    // Write vs read collision beside an independent read.
    c = cyc;
    drive(0, 1, 4'd9, 8'h9A); drive(1, 0, 4'd9, 8'h00); drive(2, 0, 4'd10, 8'h00);
    expect_ack(0, c + 2, 0, 8'h00); expect_ack(2, c + 2, 1, 8'h3A); expect_ack(1, c + 3, 1, 8'h9A);
    wait_done(3'b111);
    chk("rr_after_mixed", {30'd0, dut.rr}, 32'd1);

    // Loser drops its request before grant: never acked, never writes.
    c = cyc;
    drive(0, 1, 4'd4, 8'h4F); drive(1, 1, 4'd4, 8'h44);
    expect_ack(1, c + 2, 0, 8'h00);
    @(negedge clk); L_req = 1'b0;
    wait_done(3'b010);
`ifdef ARB_CONFLICT_CNT_EN
    chk("cnt_after_drop", {16'd0, conflict_cnt}, 32'd6);
`endif
    c = cyc;
    drive(0, 0, 4'd4, 8'h00);
    expect_ack(0, c + 2, 1, 8'h44);
    wait_done(3'b001);

    // Reset during L's write ISSUE cycle aborts it at once.
    c = cyc;
    drive(0, 1, 4'd2, 8'hEE);
    @(negedge clk);
    chk("issue_write_high", {31'd0, L_write}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_write_low", {31'd0, L_write}, 32'd0);
    chk("abort_outputs", {20'd0, L_address, M_address, R_address}, 32'd0);
    chk("abort_rdata", {8'd0, L_rdata, M_rdata, R_rdata}, 32'd0);
    chk("abort_rr", {30'd0, dut.rr}, 32'd0);
    L_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_no_ack", {29'd0, L_ack, M_ack, R_ack}, 32'd0);
`ifdef ARB_CONFLICT_CNT_EN
    chk("abort_cnt", {16'd0, conflict_cnt}, 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    c = cyc;
    drive(2, 0, 4'd2, 8'h00);
    expect_ack(2, c + 2, 1, 8'h32);
    wait_done(3'b100);

    repeat (3) @(negedge clk);
    chk("scoreboard_left", q_l.size() + q_m.size() + q_r.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
